// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg : shared UART constants, state encoding and bit-period math |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package uart_pkg;

    localparam int unsigned DEF_CLK_HZ       = 50_000_000;
    localparam int unsigned DEF_BAUD         = 9600;
    localparam int unsigned DEF_CLKS_PER_BIT = DEF_CLK_HZ / DEF_BAUD;
    localparam int unsigned DEF_HALF_BIT     = DEF_CLKS_PER_BIT / 2;

    localparam int unsigned CNT_W      = 13;
    localparam int unsigned DATA_BITS  = 8;
    localparam logic        STOP_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_sync : 2-flop synchroniser plus falling-edge detect          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_rx_sync (
    input  logic clk_50M,
    input  logic reset,
    input  logic uart_rxd,
    output logic rxd_s,
    output logic rxd_fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Flops reset to the idle level so reset release never looks like a start edge.
    always_ff @(posedge clk_50M) begin
        if (!reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= uart_rxd;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rxd_s    = sync_q;
    assign rxd_fall = prev_q & ~sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx : 8N1 UART receiver, mid-bit sampling, 1-cycle valid strobe  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_rx #(
    parameter int unsigned CLK_HZ = uart_pkg::DEF_CLK_HZ,
    parameter int unsigned BAUD   = uart_pkg::DEF_BAUD
) (
    input  logic       clk_50M,
    input  logic       reset,
    input  logic       uart_rxd,
    output logic       read_valid,
    output logic [7:0] read_value,
    output logic       frame_error,
    output logic       busy
);
    import uart_pkg::*;

    localparam int unsigned     CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int unsigned     HALF_BIT     = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] BIT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST   = CNT_W'(HALF_BIT - 1);
    localparam logic [2:0]       IDX_LAST    = 3'(DATA_BITS - 1);

    rx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       idx_q;
    logic [7:0]       shift_q;

    logic rxd_s;
    logic rxd_fall;
    logic half_hit;
    logic bit_hit;

    uart_rx_sync u_sync (
        .clk_50M  (clk_50M),
        .reset    (reset),
        .uart_rxd (uart_rxd),
        .rxd_s    (rxd_s),
        .rxd_fall (rxd_fall)
    );

    assign half_hit = (cnt_q == HALF_LAST);
    assign bit_hit  = (cnt_q == BIT_LAST);

    always_ff @(posedge clk_50M) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            read_valid  <= 1'b0;
            read_value  <= 8'h00;
            frame_error <= 1'b0;
            busy        <= 1'b0;
        end else begin
            read_valid  <= 1'b0;
            frame_error <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (rxd_fall) begin
                        state_q <= START;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    if (half_hit) begin
                        cnt_q <= '0;
                        if (!rxd_s) begin
                            state_q <= DATA;
                            idx_q   <= '0;
                        end else begin
                            // Line back high at mid start bit: treat as a glitch.
                            state_q <= IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_hit) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= rxd_s;
                        if (idx_q == IDX_LAST) begin
                            state_q <= STOP;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_hit) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        busy    <= 1'b0;
                        if (rxd_s == STOP_LEVEL) begin
                            read_value <= shift_q;
                            read_valid <= 1'b1;
                        end else begin
                            frame_error <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_rx : self-checking bench for uart_rx (scaled bit period)     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_uart_rx;

    localparam int unsigned TB_CLK_HZ = 1_600_000;
    localparam int unsigned TB_BAUD   = 100_000;
    localparam int CPB  = 16;
    localparam int HALF = 8;
    // pin edge -> sync (2) -> edge detect (1) -> half bit -> 9 bits
    localparam int LAT  = 3 + HALF + 9 * CPB;
    localparam int TOL  = 2;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        int         gap_bits;
    } vec_t;

    typedef struct {
        logic       err;
        logic [7:0] val;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxd;
    logic       read_valid;
    logic [7:0] read_value;
    logic       frame_error;
    logic       busy;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_pulses = 0;
    logic [7:0] last_good = 8'h00;
    exp_t sb[$];
    vec_t vecs[6];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx #(
        .CLK_HZ (TB_CLK_HZ),
        .BAUD   (TB_BAUD)
    ) dut (
        .clk_50M     (clk),
        .reset       (rst_n),
        .uart_rxd    (rxd),
        .read_valid  (read_valid),
        .read_value  (read_value),
        .frame_error (frame_error),
        .busy        (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic err, input logic [7:0] d);
        exp_t e;
        if (!err) last_good = d;
        e.err = err;
        e.val = last_good;
        e.cyc = cyc + LAT;
        sb.push_back(e);
    endtask

    task automatic drive_bits(input logic [7:0] d, input logic stop);
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            tick(CPB);
        end
        rxd = stop;
        tick(CPB);
        rxd = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        push_exp(!stop, d);
        drive_bits(d, stop);
    endtask

    // Scoreboard side: every strobe must match the head of the queue.
    always @(negedge clk) begin
        if (read_valid && frame_error)
            check("valid_and_ferr_together", 1, 0);
        if (read_valid || frame_error) begin
            n_pulses++;
            if (sb.size() == 0) begin
                check("unexpected_pulse_rv_fe", {read_valid, frame_error}, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_kind_ferr", frame_error, e.err);
                check("pulse_read_value", read_value, e.val);
                n_checks++;
                if (cyc < e.cyc - TOL || cyc > e.cyc + TOL) begin
                    n_fail++;
                    $display("FAIL pulse_latency: actual_cycle=%0d expected_cycle=%0d", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        vecs[0] = '{data: 8'h55, stop: 1'b1, exp_valid: 1'b1, gap_bits: 2};
        vecs[1] = '{data: 8'hA3, stop: 1'b1, exp_valid: 1'b1, gap_bits: 2};
        vecs[2] = '{data: 8'h00, stop: 1'b1, exp_valid: 1'b1, gap_bits: 2};
        vecs[3] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1'b1, gap_bits: 2};
        vecs[4] = '{data: 8'h3C, stop: 1'b0, exp_valid: 1'b0, gap_bits: 1};
        vecs[5] = '{data: 8'h81, stop: 1'b1, exp_valid: 1'b1, gap_bits: 2};

        rxd   = 1'b1;
        rst_n = 1'b0;
        tick(5);
        check("reset_busy", busy, 0);
        check("reset_read_valid", read_valid, 0);
        check("reset_frame_error", frame_error, 0);
        check("reset_read_value", read_value, 8'h00);
        rst_n = 1'b1;

        tick(500);
        check("idle_busy", busy, 0);
        check("idle_read_value", read_value, 8'h00);
        check("idle_pulses", n_pulses, 0);

        for (int i = 0; i < 6; i++) begin
            push_exp(!vecs[i].exp_valid, vecs[i].data);
            drive_bits(vecs[i].data, vecs[i].stop);
            tick(vecs[i].gap_bits * CPB);
            check("table_idle_after_frame", busy, 0);
        end

        // Back-to-back, no idle gap between stop and next start.
        send_frame(8'h12, 1'b1);
        send_frame(8'hFE, 1'b1);
        tick(2 * CPB);
        check("b2b_last_value", read_value, 8'hFE);

        // Short low glitch: START enters, then rejects at the half-bit sample.
        rxd = 1'b0;
        tick(3);
        rxd = 1'b1;
        tick(3);
        check("glitch_busy_in_start", busy, 1);
        tick(20);
        check("glitch_busy_cleared", busy, 0);
        check("glitch_read_value", read_value, 8'hFE);

        // Loopback-style frame, then reset during bit 4 of the next one.
        send_frame(8'hC7, 1'b1);
        tick(CPB);
        check("loop_value", read_value, 8'hC7);
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rxd = 1'b0 ^ ((8'h5A >> i) & 1);
            tick(CPB);
        end
        rxd = 1'b1;
        tick(CPB / 2);
        check("busy_before_abort", busy, 1);
        rst_n = 1'b0;
        tick(1);
        last_good = 8'h00;
        check("abort_busy", busy, 0);
        check("abort_read_valid", read_valid, 0);
        check("abort_frame_error", frame_error, 0);
        check("abort_read_value", read_value, 8'h00);
        tick(2);
        rst_n = 1'b1;
        tick(5 * CPB);
        check("abort_idle_busy", busy, 0);

        send_frame(8'h96, 1'b1);
        tick(2 * CPB);

        for (int i = 0; i < 400 && sb.size() != 0; i++) tick(1);
        check("scoreboard_drained", sb.size(), 0);
        check("final_read_value", read_value, 8'h96);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the receive-side counterpart of the team's uart_tx. Frame format is 8N1, LSB first, idle-high line.
- Synchronises the asynchronous uart_rxd pin, detects the start bit, samples each bit at mid-bit, and presents the received byte with a 1-cycle valid strobe.
- Sits between the board RX pin and user logic in the clk_50M domain; pairs with uart_tx for loopback.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- CLKS_PER_BIT, CLK_HZ/BAUD (5208), derived; clock cycles per bit period.
- HALF_BIT, CLKS_PER_BIT/2 (2604), derived; offset from start edge to start-bit mid sample.

Ports:
- clk_50M  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous active-low reset.
- uart_rxd  input  1  asynchronous serial line, idle high.
- read_valid  output  1  one-cycle pulse: read_value holds a new good byte.
- read_value  output  8  last correctly received byte; stable until the next good frame.
- frame_error  output  1  one-cycle pulse: stop bit sampled low.
- busy  output  1  high while a frame is being received (any state other than IDLE).

Behaviour:
- Reset (reset==0 at a clk_50M edge):
  - State goes to IDLE; bit counter and baud counter clear; synchroniser flops load 1.
  - read_valid=0, frame_error=0, busy=0, read_value=8'h00.
  - Reset mid-frame aborts the frame with no pulse.
- Input conditioning:
  - 2-flop synchroniser, then a registered copy for edge detect.
  - Falling edge = prev==1 && cur==0 on the synchronised line.
  - Synchroniser latency is 2 cycles.
- Baud counter: 13 bits, counts 0..limit-1, reloads to 0 on each sample point; it runs only outside IDLE.
- State machine:
  - IDLE:
    - On a falling edge, go to START with the counter cleared and busy=1.
    - A low line with no edge (break, line stuck low) does not start a frame.
  - START:
    - When the counter reaches HALF_BIT-1, sample the line.
    - If 0, go to DATA with bit index 0 and the counter cleared.
    - If 1 (glitch or false start), go to IDLE with no pulse.
  - DATA:
    - Every CLKS_PER_BIT cycles, sample the line into shift register bit [index], LSB first.
    - After index 7, go to STOP.
  - STOP:
    - After CLKS_PER_BIT cycles, sample the line.
    - If 1: on the next edge read_value <= shift register and read_valid=1 for exactly 1 cycle.
    - If 0: frame_error=1 for 1 cycle and read_value is unchanged.
    - Either way, return to IDLE on that same edge, with busy=0.
- Timing:
  - Nominal latency from the pin falling edge to read_valid is 2 + HALF_BIT + 9*CLKS_PER_BIT + 1 cycles (49,479 at defaults).
  - The bench tolerates ±2 cycles.
- Back-to-back frames: the next start edge can be accepted the cycle after STOP exits. There is no idle gap requirement beyond the stop half-bit.
- read_valid and frame_error are never high in the same cycle.
- Receiver tolerance: ±4% combined baud mismatch. Mid-bit sampling gives 0.5 bit margin over 10 bits.

Decomposition:
- Shared package uart_pkg:
  - CLK_HZ/BAUD defaults and the CLKS_PER_BIT and HALF_BIT derivations.
  - State encoding localparams IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3.
  - Frame constants DATA_BITS=8, STOP_LEVEL=1'b1.
  - uart_tx uses the same package for its bit period.
- One sub-module, uart_rx_sync:
  - 2-flop synchroniser plus falling-edge detect, with synchronous active-low reset.
  - Outputs rxd_s and rxd_fall.

Test Plan:
- Reset, then idle line high for 20,000 cycles -> busy=0, read_valid never asserts, read_value=8'h00.
- Drive frame 0x55 at 5208 cycles/bit -> exactly one read_valid pulse at 49,479±2 cycles after the start edge, read_value=8'h55, frame_error=0. Repeat with 0xA3, 0x00 and 0xFF.
- Back-to-back frames 0x12 then 0xFE with no idle gap -> two read_valid pulses about 52,080 cycles apart, values 0x12 then 0xFE.
- Low glitch of 1,000 cycles on an idle line -> START rejects at the half-bit sample, busy returns to 0, no pulses.
- Frame 0x3C with stop bit driven 0 -> frame_error pulses 1 cycle, read_valid=0, and read_value keeps its previous value. A following 0x81 frame sent after the line returns high for 1 bit time is received correctly.
- Loopback from uart_tx with write_value 0xC7, plus a reset asserted during bit 4 of the next frame -> first frame received as 0xC7. The aborted frame produces no pulse, and outputs return to reset values on the reset edge.
